inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Direct-mapped instruction cache between the fetch stage and the byte-serial memory controller.
- Serves fetch-PC requests from local storage on a hit.
- On a miss, issues one 32-bit word read to the memory controller and holds the address until the word returns, then writes it into the line and forwards it to fetch.
- Single outstanding miss; flush support for redirects.

Parameters:
INDEX_BITS, 6, log2 of line count (64 one-word lines)
ADDR_WIDTH, 32, address width
INST_WIDTH, 32, instruction width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
rdy  input  1  global enable; low = freeze all state
flush  input  1  fetch redirect; kills pending response
fetch_req_valid  input  1  fetch requests instruction at fetch_pc
fetch_pc  input  ADDR_WIDTH  request address, word aligned
fetch_busy  output  1  cache not in IDLE; requests ignored
fetch_inst_valid  output  1  one-cycle pulse, fetch_inst valid
fetch_inst  output  INST_WIDTH  returned instruction
mem_read_valid  output  1  miss read request to memory controller
mem_addr  output  ADDR_WIDTH  miss word address
mem_inst_valid  input  1  memory controller word ready
mem_inst  input  INST_WIDTH  assembled little-endian word

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]
  - pc[1:0] is ignored.
- Storage per line: valid bit, tag, INST_WIDTH data.
- Reset (rst low, async):
  - all valid bits cleared; state IDLE
  - fetch_inst_valid = 0, fetch_inst = 0, mem_read_valid = 0, mem_addr = 0, fetch_busy = 0
  - a miss in progress is abandoned; mem_read_valid drops immediately.
- rdy low: no state, storage or output register changes; mem_inst_valid and fetch_req_valid are ignored.
- States: IDLE, MISS, DRAIN.
- IDLE:
  - fetch_req_valid & !flush & hit: fetch_inst_valid = 1 and fetch_inst = line data at next edge (1-cycle hit latency); stay IDLE.
  - fetch_req_valid & !flush & miss: latch {pc[ADDR_WIDTH-1:2], 2'b00} into mem_addr, set mem_read_valid, go MISS.
  - flush = 1: request dropped, no output.
  - mem_inst_valid in IDLE is ignored.
- MISS:
  - mem_read_valid = 1 and mem_addr held stable every cycle.
  - on mem_inst_valid: write line (valid = 1, tag, data); clear mem_read_valid.
    - if !flush: pulse fetch_inst_valid with mem_inst at the same edge; go IDLE.
    - if flush the same cycle: line is still written, no fetch pulse; go IDLE.
  - flush without mem_inst_valid: go DRAIN; mem_read_valid stays high. The controller cannot abort a read.
- DRAIN:
  - waits for mem_inst_valid, writes the line, no fetch pulse, then IDLE.
  - further flushes have no effect.
- fetch_busy = (state != IDLE), combinational.
- Fetch holds its request until fetch_inst_valid or flush; requests arriving while busy are not queued.
- fetch_inst_valid is a single-cycle pulse; fetch_inst holds its last value otherwise.
- Exactly one mem_read_valid episode per miss; never re-issued for the same miss.
- Aliasing: same index with a different tag replaces the line (no associativity).

Decomposition:
- cpu_define.v holds AddressBus, InstBus, IndexBus, TagBus widths, state encodings (IDLE/MISS/DRAIN) and Null.
- One sub-module: inst_cache_array.
  - valid/tag/data arrays
  - one asynchronous read port by index, returning valid, tag and data
  - one synchronous write port
  - async clear of all valid bits on rst

Test Plan:
1. Release reset; request 0x00000000 -> next cycle mem_read_valid = 1, mem_addr = 0x0, fetch_busy = 1. Drive mem_inst_valid with 0x00000013 -> fetch_inst_valid pulse with fetch_inst = 0x00000013, mem_read_valid = 0, state IDLE.
2. Request 0x00000000 again -> hit. fetch_inst_valid = 1 with 0x00000013 one cycle later; mem_read_valid stays 0.
3. Request 0x00000100 (same index 0, new tag) -> miss. Refill 0xDEADBEEF and return it. Then request 0x0 -> miss again with mem_addr = 0x0.
4. Request 0x4 (miss), then flush two cycles later. Memory later returns 0x12345678 -> no fetch_inst_valid, state passes through DRAIN. Request 0x4 afterwards -> hit returning 0x12345678.
5. During MISS on 0x8, hold rdy low 3 cycles -> mem_addr stays 0x8, mem_read_valid stays 1, no state change. Restore rdy and return 0x00A00093 -> normal pulse.
6. Pull rst low mid-miss -> mem_read_valid and fetch_busy go 0 without a clock edge. After release, request 0x0 -> miss, because valid bits were cleared.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared widths, FSM encoding and reset constant for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int unsigned IndexBus   = 6;
    localparam int unsigned AddressBus = 32;
    localparam int unsigned InstBus    = 32;
    localparam int unsigned TagBus     = AddressBus - IndexBus - 2;

    localparam logic [InstBus-1:0] Null = '0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMiss  = 2'd1,
        StDrain = 2'd2
    } cache_state_e;

endpackage

// File: rtl/inst_cache_array.sv
// Line storage: valid/tag/data per index, asynchronous read port, synchronous write port.
module inst_cache_array import inst_cache_pkg::*; #(
    parameter int unsigned INDEX_BITS = IndexBus,
    parameter int unsigned TAG_WIDTH  = TagBus,
    parameter int unsigned INST_WIDTH = InstBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_WIDTH-1:0]  rd_tag_o,
    output logic [INST_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_WIDTH-1:0]  wr_tag_i,
    input  logic [INST_WIDTH-1:0] wr_data_i
);

    localparam int unsigned Lines = 1 << INDEX_BITS;

    logic [Lines-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q  [Lines];
    logic [INST_WIDTH-1:0] data_q [Lines];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_index_i] = 1'b1;
        end
    end

    // Only the valid bits need reset; tag/data are meaningless until valid is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-line instruction cache with a single outstanding miss and
// flush handling that drains a read the memory controller cannot abort.
module inst_cache import inst_cache_pkg::*; #(
    parameter int unsigned INDEX_BITS = IndexBus,
    parameter int unsigned ADDR_WIDTH = AddressBus,
    parameter int unsigned INST_WIDTH = InstBus
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  fetch_req_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_busy,
    output logic                  fetch_inst_valid,
    output logic [INST_WIDTH-1:0] fetch_inst,
    output logic                  mem_read_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_inst_valid,
    input  logic [INST_WIDTH-1:0] mem_inst
);

    localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_BITS - 2;

    cache_state_e          state_q, state_d;
    logic                  fetch_inst_valid_q, fetch_inst_valid_d;
    logic [INST_WIDTH-1:0] fetch_inst_q, fetch_inst_d;
    logic                  mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic                  rd_valid;
    logic [TagWidth-1:0]   rd_tag;
    logic [INST_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  hit;
    logic                  unused_pc_offset;

    assign unused_pc_offset = ^fetch_pc[1:0];

    inst_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_WIDTH  (TagWidth),
        .INST_WIDTH (INST_WIDTH)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (fetch_pc[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_index_i (mem_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data_i  (mem_inst)
    );

    assign hit = rd_valid && (rd_tag == fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2]);

    always_comb begin
        state_d            = state_q;
        fetch_inst_valid_d = fetch_inst_valid_q;
        fetch_inst_d       = fetch_inst_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_addr_d         = mem_addr_q;
        wr_en              = 1'b0;
        if (rdy) begin
            fetch_inst_valid_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fetch_req_valid && !flush) begin
                        if (hit) begin
                            fetch_inst_valid_d = 1'b1;
                            fetch_inst_d       = rd_data;
                        end else begin
                            mem_addr_d       = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};
                            mem_read_valid_d = 1'b1;
                            state_d          = StMiss;
                        end
                    end
                end
                StMiss: begin
                    if (mem_inst_valid) begin
                        wr_en            = 1'b1;
                        mem_read_valid_d = 1'b0;
                        state_d          = StIdle;
                        if (!flush) begin
                            fetch_inst_valid_d = 1'b1;
                            fetch_inst_d       = mem_inst;
                        end
                    end else if (flush) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    // The refill still lands in the array; only the fetch response is dropped.
                    if (mem_inst_valid) begin
                        wr_en            = 1'b1;
                        mem_read_valid_d = 1'b0;
                        state_d          = StIdle;
                    end
                end
                default: begin
                    mem_read_valid_d = 1'b0;
                    state_d          = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= StIdle;
            fetch_inst_valid_q <= 1'b0;
            fetch_inst_q       <= INST_WIDTH'(Null);
            mem_read_valid_q   <= 1'b0;
            mem_addr_q         <= '0;
        end else begin
            state_q            <= state_d;
            fetch_inst_valid_q <= fetch_inst_valid_d;
            fetch_inst_q       <= fetch_inst_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_addr_q         <= mem_addr_d;
        end
    end

    assign fetch_busy       = (state_q != StIdle);
    assign fetch_inst_valid = fetch_inst_valid_q;
    assign fetch_inst       = fetch_inst_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_addr         = mem_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Randomized bench for inst_cache: the bench acts as fetch stage and memory controller and
// predicts every response from a line-level model of the cache contents.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        fetch_req_valid;
    logic [31:0] fetch_pc;
    logic        fetch_busy;
    logic        fetch_inst_valid;
    logic [31:0] fetch_inst;
    logic        mem_read_valid;
    logic [31:0] mem_addr;
    logic        mem_inst_valid;
    logic [31:0] mem_inst;

    inst_cache dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .flush            (flush),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_pc         (fetch_pc),
        .fetch_busy       (fetch_busy),
        .fetch_inst_valid (fetch_inst_valid),
        .fetch_inst       (fetch_inst),
        .mem_read_valid   (mem_read_valid),
        .mem_addr         (mem_addr),
        .mem_inst_valid   (mem_inst_valid),
        .mem_inst         (mem_inst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Contents the cache should hold, per line index.
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] last_inst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch transaction. flush_at < 0: no flush; flush_at == lat: flush with the return.
    // rdy_at: wait cycle before which rdy drops for rdy_len cycles (with junk on mem_inst).
    task automatic fetch(input logic [31:0] pc, input int lat, input int flush_at,
                         input int rdy_at, input int rdy_len, input logic [31:0] word);
        int          i      = int'(pc[7:2]);
        logic [31:0] a      = {pc[31:2], 2'b00};
        bit          hit    = m_valid[i] && (m_tag[i] == pc[31:8]);
        bit          killed = (flush_at >= 0);
        fetch_req_valid = 1'b1;
        fetch_pc        = pc;
        step();
        fetch_req_valid = 1'b0;
        fetch_pc        = $urandom;
        if (hit) begin
            check_eq("hit_valid", fetch_inst_valid, 1);
            check_eq("hit_data", fetch_inst, m_data[i]);
            check_eq("hit_no_read", mem_read_valid, 0);
            last_inst = m_data[i];
            step();
            check_eq("hit_pulse_end", fetch_inst_valid, 0);
            return;
        end
        check_eq("miss_read", mem_read_valid, 1);
        check_eq("miss_addr", mem_addr, a);
        check_eq("miss_busy", fetch_busy, 1);
        check_eq("miss_no_pulse", fetch_inst_valid, 0);
        for (int c = 0; c < lat; c++) begin
            if (c == rdy_at) begin
                rdy            = 1'b0;
                mem_inst_valid = 1'b1;
                mem_inst       = ~word;
                for (int k = 0; k < rdy_len; k++) begin
                    step();
                    check_eq("frz_read", mem_read_valid, 1);
                    check_eq("frz_addr", mem_addr, a);
                    check_eq("frz_busy", fetch_busy, 1);
                end
                rdy            = 1'b1;
                mem_inst_valid = 1'b0;
            end
            flush = (c == flush_at);
            step();
            flush = 1'b0;
            check_eq("wait_read", mem_read_valid, 1);
            check_eq("wait_addr", mem_addr, a);
            check_eq("wait_busy", fetch_busy, 1);
            check_eq("wait_no_pulse", fetch_inst_valid, 0);
        end
        flush          = (flush_at == lat);
        mem_inst_valid = 1'b1;
        mem_inst       = word;
        step();
        flush          = 1'b0;
        mem_inst_valid = 1'b0;
        check_eq("ret_read_clear", mem_read_valid, 0);
        check_eq("ret_idle", fetch_busy, 0);
        check_eq("ret_pulse", fetch_inst_valid, !killed);
        if (!killed) last_inst = word;
        check_eq("ret_data", fetch_inst, last_inst);
        m_valid[i] = 1'b1;
        m_tag[i]   = pc[31:8];
        m_data[i]  = word;
        step();
        check_eq("ret_pulse_end", fetch_inst_valid, 0);
    endtask

    // Request with flush in IDLE, plus a stray memory strobe: both must be ignored.
    task automatic idle_flush(input logic [31:0] pc);
        fetch_req_valid = 1'b1;
        fetch_pc        = pc;
        flush           = 1'b1;
        mem_inst_valid  = 1'b1;
        mem_inst        = $urandom;
        step();
        fetch_req_valid = 1'b0;
        flush           = 1'b0;
        mem_inst_valid  = 1'b0;
        check_eq("iflush_no_pulse", fetch_inst_valid, 0);
        check_eq("iflush_no_read", mem_read_valid, 0);
        check_eq("iflush_idle", fetch_busy, 0);
        check_eq("iflush_hold", fetch_inst, last_inst);
    endtask

    initial begin
        rst             = 1'b1;
        rdy             = 1'b1;
        flush           = 1'b0;
        fetch_req_valid = 1'b0;
        fetch_pc        = '0;
        mem_inst_valid  = 1'b0;
        mem_inst        = '0;
        last_inst       = '0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        #1 rst = 1'b0;
        #1;
        check_eq("rst_pulse", fetch_inst_valid, 0);
        check_eq("rst_inst", fetch_inst, 0);
        check_eq("rst_read", mem_read_valid, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_busy", fetch_busy, 0);
        @(negedge clk);
        rst = 1'b1;

        fetch(32'h0000_0000, 2, -1, -1, 0, 32'h0000_0013);
        fetch(32'h0000_0000, 0, -1, -1, 0, 32'h0);
        fetch(32'h0000_0100, 1, -1, -1, 0, 32'hDEAD_BEEF);
        fetch(32'h0000_0000, 0, -1, -1, 0, 32'h0000_0013);
        fetch(32'h0000_0004, 4, 1, -1, 0, 32'h1234_5678);
        fetch(32'h0000_0004, 0, -1, -1, 0, 32'h0);
        fetch(32'h0000_0008, 2, -1, 0, 3, 32'h00A0_0093);
        fetch(32'h0000_000C, 1, 1, -1, 0, 32'hCAFE_F00D);
        fetch(32'h0000_000C, 0, -1, -1, 0, 32'h0);
        idle_flush(32'h0000_0008);

        // Asynchronous reset in the middle of a miss.
        fetch_req_valid = 1'b1;
        fetch_pc        = 32'h0000_0040;
        step();
        fetch_req_valid = 1'b0;
        check_eq("pre_rst_read", mem_read_valid, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_read", mem_read_valid, 0);
        check_eq("async_rst_busy", fetch_busy, 0);
        check_eq("async_rst_inst", fetch_inst, 0);
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        last_inst = '0;
        @(negedge clk);
        rst = 1'b1;
        fetch(32'h0000_0000, 1, -1, -1, 0, 32'h0000_0013);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] pc;
            int          lat, fa, ra;
            pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            lat = $urandom_range(0, 4);
            fa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
            ra  = (lat > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, lat - 1) : -1;
            if ($urandom_range(0, 9) == 0) idle_flush(pc);
            else fetch(pc, lat, fa, ra, $urandom_range(1, 3), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
